root_scheduler: RTL and testbench

- Round-robin scheduler that shares one fixed-point nth-root engine among N_REQ requesters.
- The engine computes the 10.10 result of in_data_1^(1/in_data_2).
- Accepts one request at a time, latches its operands, launches the engine, and holds the engine operands stable for the whole computation. The engine samples them on every iteration.
- Returns the result to the granted requester with its ID; a watchdog covers a hung engine.

---
 rtl/root_scheduler.sv | 159 +++++++++++++++
 tb/tb_root_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/root_scheduler.sv
// root_scheduler: round-robin arbiter in front of a single shared fixed-point
// nth-root engine. It accepts one request at a time, holds the operands on the
// engine for the whole computation, and returns the result (or a watchdog
// abort) to the requester it granted.
module root_scheduler #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [10*N_REQ-1:0]   req_data_1,
   input  logic [3*N_REQ-1:0]    req_data_2,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      resp_valid,
   output logic [ID_W-1:0]       resp_id,
   output logic [19:0]           resp_data,
   output logic                  resp_err,
   output logic                  eng_in_valid,
   output logic [9:0]            eng_in_data_1,
   output logic [2:0]            eng_in_data_2,
   input  logic                  eng_out_valid,
   input  logic [19:0]           eng_out_data,
   output logic                  busy,
   output logic                  timeout_flag
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [9:0] TO_CNT = 10'(TIMEOUT);

   state_t            r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_gnt;
   logic [9:0]        r_d1;
   logic [2:0]        r_d2;
   logic [9:0]        r_wd;
   logic              r_eng_in_valid;
   logic              r_busy;
   logic              r_timeout_flag;
   logic [N_REQ-1:0]  r_resp_valid;
   logic [ID_W-1:0]   r_resp_id;
   logic [19:0]       r_resp_data;
   logic              r_resp_err;

   logic              w_found;
   logic [ID_W-1:0]   w_win;
   logic [ID_W:0]     w_idx;
   logic [N_REQ-1:0]  w_req_ready;
   logic [9:0]        w_d1 [N_REQ];
   logic [2:0]        w_d2 [N_REQ];

   // Unpack the flat per-requester operand buses.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_d1[gi] = req_data_1[10*gi +: 10];
      assign w_d2[gi] = req_data_2[3*gi +: 3];
   end

   // Round-robin search starting at r_rr_ptr; the first valid requester wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(N_REQ))
            w_idx = w_idx - (ID_W+1)'(N_REQ);
         if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[ID_W-1:0];
         end
      end
   end

   // Accept is offered only while idle, one-hot to the winner.
   always_comb begin
      w_req_ready = '0;
      if (r_state == S_IDLE && w_found)
         w_req_ready[w_win] = 1'b1;
   end

   // Control FSM with registered outputs. Response fields are loaded on the
   // WAIT->RESP edge so they are visible exactly during RESP and zero otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_rr_ptr       <= '0;
         r_gnt          <= '0;
         r_d1           <= '0;
         r_d2           <= '0;
         r_wd           <= '0;
         r_eng_in_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_timeout_flag <= 1'b0;
         r_resp_valid   <= '0;
         r_resp_id      <= '0;
         r_resp_data    <= '0;
         r_resp_err     <= 1'b0;
      end else begin
         r_eng_in_valid <= 1'b0;
         r_resp_valid   <= '0;
         r_resp_id      <= '0;
         r_resp_data    <= '0;
         r_resp_err     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_gnt          <= w_win;
                  r_d1           <= w_d1[w_win];
                  r_d2           <= w_d2[w_win];
                  r_wd           <= '0;
                  r_eng_in_valid <= 1'b1;
                  r_busy         <= 1'b1;
                  r_state        <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               // A real result beats the watchdog in the same cycle.
               if (eng_out_valid) begin
                  r_resp_valid <= N_REQ'(1) << r_gnt;
                  r_resp_id    <= r_gnt;
                  r_resp_data  <= eng_out_data;
                  r_resp_err   <= 1'b0;
                  r_state      <= S_RESP;
               end else if (r_wd == TO_CNT) begin
                  r_resp_valid   <= N_REQ'(1) << r_gnt;
                  r_resp_id      <= r_gnt;
                  r_resp_data    <= 20'hFFFFF;
                  r_resp_err     <= 1'b1;
                  r_timeout_flag <= 1'b1;
                  r_state        <= S_RESP;
               end else begin
                  r_wd <= r_wd + 10'd1;
               end
            end
            S_RESP: begin
               r_rr_ptr <= (r_gnt == ID_W'(N_REQ-1)) ? '0 : r_gnt + ID_W'(1);
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = w_req_ready;
   assign resp_valid    = r_resp_valid;
   assign resp_id       = r_resp_id;
   assign resp_data     = r_resp_data;
   assign resp_err      = r_resp_err;
   assign eng_in_valid  = r_eng_in_valid;
   assign eng_in_data_1 = r_d1;
   assign eng_in_data_2 = r_d2;
   assign busy          = r_busy;
   assign timeout_flag  = r_timeout_flag;

endmodule

// File: tb/tb_root_scheduler.sv
// Scoreboard bench for root_scheduler: directed requests push expected
// responses, a negedge monitor pops and compares on every resp_valid.
module tb_root_scheduler;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [10*N-1:0] req_data_1;
   logic [3*N-1:0]  req_data_2;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    resp_valid;
   logic [1:0]      resp_id;
   logic [19:0]     resp_data;
   logic            resp_err;
   logic            eng_in_valid;
   logic [9:0]      eng_in_data_1;
   logic [2:0]      eng_in_data_2;
   logic            eng_out_valid;
   logic [19:0]     eng_out_data;
   logic            busy;
   logic            timeout_flag;

   always #5 clk = ~clk;

   root_scheduler #(.N_REQ(N), .ID_W(2), .TIMEOUT(1023)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data_1(req_data_1), .req_data_2(req_data_2),
      .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
      .eng_in_valid(eng_in_valid), .eng_in_data_1(eng_in_data_1), .eng_in_data_2(eng_in_data_2),
      .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
      .busy(busy), .timeout_flag(timeout_flag)
   );

   typedef struct {
      logic [1:0]  id;
      logic [9:0]  d1;
      logic [2:0]  d2;
      logic [19:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   rem [N];
   int   cyc = 0, t_issue = 0, last_lat = 0;

   // Engine model: result appears e_delay cycles after the eng_in_valid cycle.
   int          e_delay = 20;
   logic        e_hang  = 1'b0;
   logic        e_busy;
   int          e_cnt;
   logic [9:0]  e_d1;
   logic [2:0]  e_d2;

   function automatic logic [19:0] root_ref(logic [9:0] a, logic [2:0] n);
      logic [12:0] key;
      key = {a, n};
      case (key)
         {10'd16, 3'd2}: return 20'h01000;  // sqrt(16)  = 4.0
         {10'd8,  3'd3}: return 20'h00800;  // cbrt(8)   = 2.0
         {10'd27, 3'd3}: return 20'h00C00;  // cbrt(27)  = 3.0
         {10'd64, 3'd3}: return 20'h01000;  // cbrt(64)  = 4.0
         {10'd1,  3'd3}: return 20'h00400;  // cbrt(1)   = 1.0
         default:        return 20'h00000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         e_busy <= 1'b0; e_cnt <= 0; e_d1 <= '0; e_d2 <= '0;
         eng_out_valid <= 1'b0; eng_out_data <= '0;
      end else begin
         eng_out_valid <= 1'b0;
         eng_out_data  <= '0;
         if (eng_in_valid) begin
            e_busy <= 1'b1; e_cnt <= 1; e_d1 <= eng_in_data_1; e_d2 <= eng_in_data_2;
         end else if (e_busy && !e_hang) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt == e_delay - 1) begin
               eng_out_valid <= 1'b1;
               eng_out_data  <= root_ref(e_d1, e_d2);
               e_busy        <= 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input int d1, input int d2, input logic [19:0] data, input logic err);
      exp_t x;
      x.id = 2'(id); x.d1 = 10'(d1); x.d2 = 3'(d2); x.data = data; x.err = err;
      sb.push_back(x);
   endtask

   // Advance one cycle; requesters drop valid once all their requests are accepted.
   task automatic tick();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] && rem[i] > 0) rem[i]--;
         req_valid[i] = (rem[i] != 0);
      end
   endtask

   task automatic set_req(input int i, input int n, input int d1, input int d2);
      rem[i] = n;
      req_data_1[10*i +: 10] = 10'(d1);
      req_data_2[3*i +: 3]   = 3'(d2);
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      logic done;
      done = 1'b0;
      for (int k = 0; k < max_cyc && !done; k++) begin
         if (sb.size() == 0 && !busy && req_valid == '0) done = 1'b1;
         else tick();
      end
      if (!done) check({name, "_bound"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset(input string name);
      check({name, "_ctl"}, {busy, eng_in_valid, timeout_flag, resp_err, req_ready, resp_valid}, 32'd0);
      check({name, "_dat"}, {resp_id, resp_data, eng_in_data_2}, 32'd0);
      check({name, "_op"}, 32'(eng_in_data_1), 32'd0);
   endtask

   // Monitor: every response is matched against the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (eng_in_valid) t_issue = cyc;
         if (resp_valid != '0) begin
            last_lat = cyc - t_issue;
            if (sb.size() == 0) begin
               check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
               e_mon = sb.pop_front();
               check("resp_valid_onehot", 32'(resp_valid), 32'd1 << e_mon.id);
               check("resp_id", 32'(resp_id), 32'(e_mon.id));
               check("resp_data", 32'(resp_data), 32'(e_mon.data));
               check("resp_err", 32'(resp_err), 32'(e_mon.err));
               check("eng_hold_ops", {eng_in_data_1, eng_in_data_2}, {e_mon.d1, e_mon.d2});
               check("eng_issued_ops", {e_d1, e_d2}, {e_mon.d1, e_mon.d2});
            end
         end else if (rst_n) begin
            check("idle_resp_zero", {resp_id, resp_data}, 32'd0);
         end
         if (req_ready != '0)
            check("ready_legal", {busy, $onehot(req_ready), |(req_ready & ~req_valid)}, 32'b010);
      end
   end

   initial begin
      rst_n = 1'b0; req_valid = '0; req_data_1 = '0; req_data_2 = '0;
      for (int i = 0; i < N; i++) rem[i] = 0;
      tick(); tick();
      check_reset("reset");
      rst_n = 1'b1;

      // Single request on requester 2: sqrt(16).
      set_req(2, 1, 16, 2);
      push(2, 16, 2, 20'h01000, 1'b0);
      tick();
      check("t1_issue", {eng_in_valid, eng_in_data_1, eng_in_data_2}, {1'b1, 10'd16, 3'd2});
      tick();
      check("t1_issue_pulse", 32'(eng_in_valid), 32'd0);
      wait_done("t1", 200);
      check("t1_latency", 32'(last_lat), 32'd21);

      // All four valid from reset: grant order 0,1,2,3.
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      set_req(0, 1, 8, 3);  set_req(1, 1, 27, 3);
      set_req(2, 1, 64, 3); set_req(3, 1, 1, 3);
      push(0, 8, 3, 20'h00800, 1'b0);  push(1, 27, 3, 20'h00C00, 1'b0);
      push(2, 64, 3, 20'h01000, 1'b0); push(3, 1, 3, 20'h00400, 1'b0);
      wait_done("t2", 400);

      // Requester 0 continuously valid with requester 3: alternate 0,3,0,3.
      set_req(0, 2, 16, 2); set_req(3, 2, 27, 3);
      push(0, 16, 2, 20'h01000, 1'b0); push(3, 27, 3, 20'h00C00, 1'b0);
      push(0, 16, 2, 20'h01000, 1'b0); push(3, 27, 3, 20'h00C00, 1'b0);
      wait_done("t3", 400);

      // Hung engine: watchdog abort, sticky flag, next request served normally.
      e_hang = 1'b1;
      set_req(1, 1, 64, 3);
      push(1, 64, 3, 20'hFFFFF, 1'b1);
      wait_done("t4", 1300);
      check("t4_timeout_latency", 32'(last_lat), 32'd1025);
      check("t4_flag_set", 32'(timeout_flag), 32'd1);
      e_hang = 1'b0;
      set_req(2, 1, 8, 3);
      push(2, 8, 3, 20'h00800, 1'b0);
      wait_done("t4b", 200);
      check("t4_flag_sticky", 32'(timeout_flag), 32'd1);

      // Reset during WAIT: no response for the aborted request, pointer back to 0.
      e_delay = 50;
      set_req(1, 1, 8, 3);
      for (int k = 0; k < 10 && !eng_in_valid; k++) tick();
      for (int k = 0; k < 5; k++) tick();
      check("t5_in_wait", 32'(busy), 32'd1);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check_reset("t5_reset");
      e_delay = 20;
      set_req(1, 1, 8, 3); set_req(3, 1, 1, 3);
      push(1, 8, 3, 20'h00800, 1'b0); push(3, 1, 3, 20'h00400, 1'b0);
      wait_done("t5", 400);

      // Result arrives in the cycle the watchdog reaches TIMEOUT: WAIT starts with
      // the watchdog at 0, so that is the 1024th cycle after eng_in_valid.
      e_delay = 1024;
      set_req(0, 1, 16, 2);
      push(0, 16, 2, 20'h01000, 1'b0);
      wait_done("t6", 1300);
      check("t6_latency", 32'(last_lat), 32'd1025);
      check("t6_flag_clear", 32'(timeout_flag), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
